// File: rtl/pc_reg.sv
// pc_reg: fetch PC register with a 128-entry 2-bit BHT and tagged BTB
// giving a zero-latency next-PC prediction.
module pc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] pc_o,
    output logic [6:0]  br_index_o,
    output logic        prd_jmp_o
);
    logic [127:0][1:0] bht;
    logic [127:0]      btb_valid;
    logic [9:0]        btb_tag    [128];
    logic [31:0]       btb_target [128];
    logic [6:0]        upd_idx;
    logic [1:0]        cnt, cnt_nxt;
    logic              btb_hit;
    logic [31:0]       next_pc;
    logic              upd_en, btb_wr;
    assign br_index_o = pc_o[8:2];
    assign btb_hit    = btb_valid[br_index_o] && btb_tag[br_index_o] == pc_o[18:9];
    assign prd_jmp_o  = btb_hit && bht[br_index_o][1];
    assign next_pc    = prd_jmp_o ? btb_target[br_index_o] : pc_o + 32'd4;
    assign upd_idx    = upd_pc[8:2];
    assign cnt        = bht[upd_idx];
    assign upd_en     = rdy && upd_valid;
    assign btb_wr     = upd_en && upd_taken;
    always_comb begin
        cnt_nxt = cnt;
        if (upd_taken)
            cnt_nxt = (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            cnt_nxt = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o      <= 32'h0;
            bht       <= {128{2'b01}};
            btb_valid <= '0;
        end else if (rdy) begin
            pc_o <= jmp ? jmp_target : stall ? pc_o : next_pc;
            if (upd_en)
                bht[upd_idx] <= cnt_nxt;
            if (btb_wr)
                btb_valid[upd_idx] <= 1'b1;
        end
    end
    // tag/target need no reset: they are only observed through btb_valid
    always_ff @(posedge clk) begin
        if (!rst && btb_wr) begin
            btb_tag[upd_idx]    <= upd_pc[18:9];
            btb_target[upd_idx] <= upd_target;
        end
    end
endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: directed stimulus for pc_reg with a queue-based scoreboard
// checked by an independent monitor on the falling clock edge.
module tb_pc_reg;
    logic        clk = 1'b0;
    logic        rst, rdy, stall, jmp, upd_valid, upd_taken;
    logic [31:0] jmp_target, upd_pc, upd_target;
    logic [31:0] pc_o;
    logic [6:0]  br_index_o;
    logic        prd_jmp_o;

    typedef struct {
        logic [31:0] pc;
        logic        prd;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pc_reg dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .jmp(jmp),
        .jmp_target(jmp_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .pc_o(pc_o), .br_index_o(br_index_o), .prd_jmp_o(prd_jmp_o)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (pc_o !== e.pc || prd_jmp_o !== e.prd || br_index_o !== e.pc[8:2]) begin
                mismatched++;
                $display("FAIL %s: got pc=%h prd=%b idx=%h, expected pc=%h prd=%b idx=%h",
                         e.nm, pc_o, prd_jmp_o, br_index_o, e.pc, e.prd, e.pc[8:2]);
            end
        end
    end

    task automatic cyc(input logic r, input logic rd, input logic st, input logic j,
                       input logic [31:0] jt, input logic uv, input logic ut,
                       input logic [31:0] upc, input logic [31:0] utg,
                       input logic [31:0] ep, input logic eprd, input string nm);
        rst = r; rdy = rd; stall = st; jmp = j; jmp_target = jt;
        upd_valid = uv; upd_taken = ut; upd_pc = upc; upd_target = utg;
        q.push_back('{pc: ep, prd: eprd, nm: nm});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; stall = 1'b0; jmp = 1'b0; jmp_target = '0;
        upd_valid = 1'b0; upd_taken = 1'b0; upd_pc = '0; upd_target = '0;
        @(posedge clk);
        #1;
        //  rst rdy st jmp target        uv ut upc    utgt   exp_pc         prd
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h0,        0, "reset_pc0");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h4,        0, "seq_4");
        cyc(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h8,        0, "seq_8_stall1");
        cyc(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h8,        0, "stall_hold2");
        cyc(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h8,        0, "stall_hold3");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h8,        0, "stall_release");
        cyc(0, 0, 0, 1, 32'h500,      1, 1, 32'h10, 32'h40, 32'hC,        0, "rdy_low1");
        cyc(0, 0, 0, 0, 32'h0,        1, 1, 32'h10, 32'h40, 32'hC,        0, "rdy_low2");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'hC,        0, "rdy_low_hold");
        cyc(0, 1, 1, 1, 32'h100,      0, 0, 32'h0,  32'h0,  32'h10,       0, "rdy_low_no_update");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h100,      0, "jmp_over_stall");
        cyc(0, 1, 0, 0, 32'h0,        1, 1, 32'h10, 32'h40, 32'h104,      0, "seq_104_upd_t1");
        cyc(0, 1, 0, 1, 32'h10,       1, 1, 32'h10, 32'h40, 32'h108,      0, "seq_108_upd_t2");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h10,       1, "predict_taken");
        cyc(0, 1, 0, 1, 32'h210,      0, 0, 32'h0,  32'h0,  32'h40,       0, "btb_target");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h210,      0, "tag_miss");
        cyc(0, 1, 0, 1, 32'h10,       0, 0, 32'h0,  32'h0,  32'h214,      0, "tag_miss_next");
        cyc(0, 1, 1, 0, 32'h0,        1, 0, 32'h10, 32'h0,  32'h10,       1, "nt1_same_cycle_old");
        cyc(0, 1, 1, 0, 32'h0,        1, 0, 32'h10, 32'h0,  32'h10,       1, "nt2_ctr_10");
        cyc(0, 1, 1, 0, 32'h0,        1, 0, 32'h10, 32'h0,  32'h10,       0, "nt3_ctr_01");
        cyc(0, 1, 0, 0, 32'h0,        1, 1, 32'h10, 32'h80, 32'h10,       0, "ctr_00_no_pred");
        cyc(0, 1, 0, 1, 32'h10,       0, 0, 32'h0,  32'h0,  32'h14,       0, "after_saturate");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h10,       0, "ctr_01_no_pred");
        cyc(1, 1, 0, 1, 32'h300,      1, 1, 32'h10, 32'h40, 32'h14,       0, "rst_midstream");
        cyc(0, 1, 0, 1, 32'h10,       0, 0, 32'h0,  32'h0,  32'h0,        0, "rst_drops_jmp");
        cyc(0, 1, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0,  32'h0,  32'h10,       0, "rst_cleared_btb");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'hFFFFFFFC, 0, "wrap_top");
        cyc(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h0,        0, "wrap_zero");
        @(negedge clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish by 100000, expected finish");
        $fatal(1, "timeout");
    end
endmodule
